// File: rtl/memory_arbiter_pkg.sv
// Shared types and codes for the I/D-cache memory arbiter.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_W  = 28;
    localparam int DEF_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // Owner codes double as indices into per-requester vectors.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

    function automatic logic [1:0] grant_code(input owner_e o);
        return (o == OWN_D) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of both cache-side ports, the data_memory port and the grant indicator.
interface memory_arbiter_if import memory_arbiter_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
);

    logic               I_READ;
    logic [ADDR_W-1:0]  I_ADDRESS;
    logic [BLOCK_W-1:0] I_READDATA;
    logic               I_BUSYWAIT;

    logic               D_READ;
    logic               D_WRITE;
    logic [ADDR_W-1:0]  D_ADDRESS;
    logic [BLOCK_W-1:0] D_WRITEDATA;
    logic [BLOCK_W-1:0] D_READDATA;
    logic               D_BUSYWAIT;

    logic               MEM_READ;
    logic               MEM_WRITE;
    logic [ADDR_W-1:0]  MEM_ADDRESS;
    logic [BLOCK_W-1:0] MEM_WRITEDATA;
    logic [BLOCK_W-1:0] MEM_READDATA;
    logic               MEM_BUSYWAIT;

    logic [1:0]         GRANT;

    // master: the arbiter, which drives memory and stalls the caches
    modport master (
        input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT,
        output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, GRANT
    );

    // slave: the caches and data_memory surrounding the arbiter
    modport slave (
        output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT,
        input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, GRANT
    );

endinterface

// File: rtl/memory_arbiter.sv
// Locks data_memory to one cache per transaction; the lock is held until the
// owner drops every request line, so a write-back plus refill stays atomic.
module memory_arbiter import memory_arbiter_pkg::*; #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET,
    memory_arbiter_if.master bus
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e last_q,  last_d;

    logic [1:0] pend;
    logic [1:0] busy;
    logic       owner_pend;
    logic       other_pend;
    logic       fwd;
    logic       owner_busy;

    assign pend[OWN_I] = bus.I_READ;
    assign pend[OWN_D] = bus.D_READ | bus.D_WRITE;
    assign owner_pend  = pend[owner_q];
    assign other_pend  = pend[other_owner(owner_q)];
    assign fwd         = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pend[OWN_I] || pend[OWN_D]) begin
                    state_d = ST_ISSUE;
                    if (pend[OWN_I] && pend[OWN_D])
                        owner_d = RR_ENABLE ? other_owner(last_q) : OWN_D;
                    else
                        owner_d = pend[OWN_D] ? OWN_D : OWN_I;
                end
            end
            ST_ISSUE: begin
                if (owner_pend) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            ST_ACTIVE: begin
                if (!owner_pend) begin
                    last_d = owner_q;
                    // Hand straight over to a waiting requester without an IDLE bubble.
                    if (other_pend) begin
                        owner_d = other_owner(owner_q);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        if (fwd) begin
            if (owner_q == OWN_D) begin
                bus.MEM_WRITE     = bus.D_WRITE;
                bus.MEM_READ      = bus.D_READ & ~bus.D_WRITE;
                bus.MEM_ADDRESS   = bus.D_ADDRESS;
                bus.MEM_WRITEDATA = bus.D_WRITEDATA;
            end else begin
                bus.MEM_READ      = bus.I_READ;
                bus.MEM_ADDRESS   = bus.I_ADDRESS;
            end
        end
    end

    // The ISSUE cycle hides the memory's late busywait rise from the owner.
    assign owner_busy = (state_q == ST_ISSUE) | bus.MEM_BUSYWAIT;

    for (genvar gi = 0; gi < 2; gi++) begin : g_busy
        assign busy[gi] = (fwd && owner_q == owner_e'(1'(gi))) ? owner_busy : pend[gi];
    end

    assign bus.I_BUSYWAIT = busy[OWN_I];
    assign bus.D_BUSYWAIT = busy[OWN_D];
    assign bus.I_READDATA = bus.MEM_READDATA;
    assign bus.D_READDATA = bus.MEM_READDATA;
    assign bus.GRANT      = fwd ? grant_code(owner_q) : GRANT_NONE;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench: behavioural data_memory, I/D requester tasks, and a monitor on the memory port.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int AW      = DEF_ADDR_W;
    localparam int BW      = DEF_BLOCK_W;
    localparam int MEM_LAT = 3;

    typedef struct packed {
        logic [1:0]    grant;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();
    memory_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus2 ();

    memory_arbiter #(.RR_ENABLE(1'b1)) dut    (.CLK(clk), .RESET(rst), .bus(bus));
    memory_arbiter #(.RR_ENABLE(1'b0)) dut_fp (.CLK(clk), .RESET(rst), .bus(bus2));

    txn_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   idle_pend = 0;

    localparam logic [BW-1:0] W3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [BW-1:0] W7 = 128'hABCD1234;

    function automatic logic [BW-1:0] blk_init(input int a);
        return {32'(a), 32'hC0DE_0000 | 32'(a), 32'(a * 3 + 1), 32'h5A5A_0000 ^ 32'(a)};
    endfunction

    function automatic txn_t mk(input logic [1:0] g, input logic r, input logic w,
                                input logic [AW-1:0] a, input logic [BW-1:0] wd);
        txn_t t;
        t.grant = g; t.rd = r; t.wr = w; t.addr = a; t.wdata = wd;
        return t;
    endfunction

    // Behavioural data_memory: busywait rises one edge after an idle cycle, else at once.
    logic [BW-1:0] mem [0:63];
    logic          mem_req, mem_match, served, idle_prev;
    logic [AW+1:0] mem_key, served_key;
    logic [5:0]    mem_idx;
    int            mem_cnt;

    assign mem_req   = bus.MEM_READ | bus.MEM_WRITE;
    assign mem_key   = {bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDRESS};
    assign mem_idx   = bus.MEM_ADDRESS[5:0];
    assign mem_match = served && (mem_key == served_key);
    assign bus.MEM_BUSYWAIT = mem_req && !mem_match && !idle_prev;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= blk_init(i);
            served           <= 1'b0;
            served_key       <= '0;
            idle_prev        <= 1'b1;
            mem_cnt          <= 0;
            bus.MEM_READDATA <= '0;
        end else if (!mem_req) begin
            served    <= 1'b0;
            idle_prev <= 1'b1;
            mem_cnt   <= 0;
        end else begin
            idle_prev <= 1'b0;
            if (!mem_match) begin
                if (mem_cnt == MEM_LAT - 1) begin
                    mem_cnt    <= 0;
                    served     <= 1'b1;
                    served_key <= mem_key;
                    if (bus.MEM_WRITE) mem[mem_idx] <= bus.MEM_WRITEDATA;
                    else               bus.MEM_READDATA <= mem[mem_idx];
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [AW+1:0] prev_key = '0;
        logic          prev_valid = 1'b0;
        txn_t          act, exp;
        logic          owner_bw;
        forever begin
            @(negedge clk);
            if (bus.GRANT == GRANT_NONE && (bus.I_READ || bus.D_READ || bus.D_WRITE))
                idle_pend++;
            if (rst || !(bus.MEM_READ || bus.MEM_WRITE)) begin
                prev_valid = 1'b0;
            end else begin
                if (!prev_valid || mem_key != prev_key) begin
                    act = mk(bus.GRANT, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDRESS, bus.MEM_WRITEDATA);
                    owner_bw = (bus.GRANT == GRANT_D) ? bus.D_BUSYWAIT : bus.I_BUSYWAIT;
                    $display("txn grant=%b rd=%b wr=%b addr=%h wdata=%h", act.grant, act.rd, act.wr, act.addr, act.wdata);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_txn: got %0h expected none", act);
                    end else begin
                        exp = exp_q.pop_front();
                        check("mem_txn", 256'(act), 256'(exp));
                        check("owner_busy_at_start", 256'(owner_bw), 256'(1'b1));
                    end
                end
                prev_valid = 1'b1;
                prev_key   = mem_key;
            end
        end
    endtask

    task automatic i_req(input logic [AW-1:0] a, input logic [BW-1:0] exp_data);
        bit done = 1'b0;
        @(posedge clk); #1;
        bus.I_READ = 1'b1; bus.I_ADDRESS = a;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.I_BUSYWAIT) begin done = 1'b1; break; end
        end
        check("i_complete", 256'(done), 256'(1'b1));
        check("i_readdata", 256'(bus.I_READDATA), 256'(exp_data));
        @(posedge clk); #1;
        bus.I_READ = 1'b0;
    endtask

    task automatic d_req(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] wd, input logic [BW-1:0] exp_data, input bit keep);
        bit done = 1'b0;
        @(posedge clk); #1;
        bus.D_READ = r; bus.D_WRITE = w; bus.D_ADDRESS = a; bus.D_WRITEDATA = wd;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.D_BUSYWAIT) begin done = 1'b1; break; end
        end
        check("d_complete", 256'(done), 256'(1'b1));
        if (r && !w) check("d_readdata", 256'(bus.D_READDATA), 256'(exp_data));
        if (!keep) begin
            @(posedge clk); #1;
            bus.D_READ = 1'b0; bus.D_WRITE = 1'b0;
        end
    endtask

    int base;

    initial begin
        rst = 1'b1;
        bus.I_READ = 1'b1; bus.I_ADDRESS = 28'h0ABCDEF;
        bus.D_READ = 1'b0; bus.D_WRITE = 1'b1; bus.D_ADDRESS = 28'h0123456;
        bus.D_WRITEDATA = 128'hDEAD_BEEF;
        bus2.I_READ = 1'b0; bus2.I_ADDRESS = '0; bus2.D_READ = 1'b0; bus2.D_WRITE = 1'b0;
        bus2.D_ADDRESS = '0; bus2.D_WRITEDATA = '0; bus2.MEM_READDATA = '0; bus2.MEM_BUSYWAIT = 1'b0;
        fork monitor(); join_none

        // Reset state with requests present: no forwarding, requesters stalled.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant",     256'(bus.GRANT), 256'(GRANT_NONE));
        check("rst_mem_read",  256'(bus.MEM_READ), 256'(1'b0));
        check("rst_mem_write", 256'(bus.MEM_WRITE), 256'(1'b0));
        check("rst_mem_addr",  256'(bus.MEM_ADDRESS), 256'(0));
        check("rst_mem_wdata", 256'(bus.MEM_WRITEDATA), 256'(0));
        check("rst_i_busy",    256'(bus.I_BUSYWAIT), 256'(1'b1));
        check("rst_d_busy",    256'(bus.D_BUSYWAIT), 256'(1'b1));
        bus.I_READ = 1'b0; bus.D_WRITE = 1'b0;
        #1;
        check("rst_i_busy_idle", 256'(bus.I_BUSYWAIT), 256'(1'b0));
        check("rst_d_busy_idle", 256'(bus.D_BUSYWAIT), 256'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // First tie after reset goes to D, then I without an IDLE bubble.
        base = idle_pend;
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h0000005, '0));
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h0000008, '0));
        fork
            d_req(1'b1, 1'b0, 28'h0000005, '0, blk_init(5), 1'b0);
            i_req(28'h0000008, blk_init(8));
        join
        check("idle_cycles_tie", 256'(idle_pend - base), 256'(1));

        // I alone.
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h0000010, '0));
        i_req(28'h0000010, blk_init(16));

        // Write-back then refill stays locked to D while I waits.
        base = idle_pend;
        exp_q.push_back(mk(GRANT_D, 1'b0, 1'b1, 28'h0000003, W3));
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h0000013, '0));
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h0000010, '0));
        fork
            begin
                d_req(1'b0, 1'b1, 28'h0000003, W3, '0, 1'b1);
                d_req(1'b1, 1'b0, 28'h0000013, '0, blk_init(19), 1'b0);
            end
            begin
                @(posedge clk);
                i_req(28'h0000010, blk_init(16));
            end
        join
        check("idle_cycles_wb", 256'(idle_pend - base), 256'(1));

        // Read and write together: write wins.
        exp_q.push_back(mk(GRANT_D, 1'b0, 1'b1, 28'h0000007, W7));
        d_req(1'b1, 1'b1, 28'h0000007, W7, '0, 1'b0);

        // Tie after D owned last: round-robin gives I first; both read written data back.
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h0000007, '0));
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h0000003, '0));
        fork
            i_req(28'h0000007, W7);
            d_req(1'b1, 1'b0, 28'h0000003, '0, W3, 1'b0);
        join

        // Continuous contention: last owner D, so I,D,I,D.
        base = idle_pend;
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h0000030, '0));
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h0000020, '0));
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h0000031, '0));
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h0000021, '0));
        fork
            begin
                d_req(1'b1, 1'b0, 28'h0000020, '0, blk_init(32), 1'b0);
                d_req(1'b1, 1'b0, 28'h0000021, '0, blk_init(33), 1'b0);
            end
            begin
                i_req(28'h0000030, blk_init(48));
                i_req(28'h0000031, blk_init(49));
            end
        join
        check("idle_cycles_rr", 256'(idle_pend - base), 256'(1));

        // Reset while D is ACTIVE aborts the transaction.
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h000000A, '0));
        @(posedge clk); #1;
        bus.D_READ = 1'b1; bus.D_ADDRESS = 28'h000000A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("active_grant",    256'(bus.GRANT), 256'(GRANT_D));
        check("active_mem_read", 256'(bus.MEM_READ), 256'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.D_READ = 1'b0;
        @(negedge clk);
        check("abort_grant",     256'(bus.GRANT), 256'(GRANT_NONE));
        check("abort_mem_read",  256'(bus.MEM_READ), 256'(1'b0));
        check("abort_mem_write", 256'(bus.MEM_WRITE), 256'(1'b0));
        check("abort_d_busy",    256'(bus.D_BUSYWAIT), 256'(1'b0));

        // After reset the tie goes to D again.
        exp_q.push_back(mk(GRANT_D, 1'b1, 1'b0, 28'h000000B, '0));
        exp_q.push_back(mk(GRANT_I, 1'b1, 1'b0, 28'h000000C, '0));
        fork
            d_req(1'b1, 1'b0, 28'h000000B, '0, blk_init(11), 1'b0);
            i_req(28'h000000C, blk_init(12));
        join

        // Fixed-priority instance: D wins a tie even when D owned last.
        @(posedge clk); #1;
        bus2.D_READ = 1'b1; bus2.D_ADDRESS = 28'h0000015; bus2.I_ADDRESS = 28'h0000016;
        @(negedge clk);
        check("fp_idle_grant", 256'(bus2.GRANT), 256'(GRANT_NONE));
        @(posedge clk); #1;
        @(negedge clk);
        check("fp_issue_grant", 256'(bus2.GRANT), 256'(GRANT_D));
        @(posedge clk); #1;
        bus2.D_READ = 1'b0;
        @(posedge clk); #1;
        bus2.I_READ = 1'b1; bus2.D_READ = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("fp_tie_grant", 256'(bus2.GRANT), 256'(GRANT_D));
        check("fp_tie_addr",  256'(bus2.MEM_ADDRESS), 256'(28'h0000015));
        check("fp_tie_i_busy", 256'(bus2.I_BUSYWAIT), 256'(1'b1));
        bus2.I_READ = 1'b0; bus2.D_READ = 1'b0;

        for (int n = 0; n < 50; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
